// File: rtl/routing_cfg_loader.sv
// routing_cfg_loader: streams WORD_W-bit configuration words into a shadow
// register and commits the shadow to every routing block's cfg bus on one
// edge, so the fabric never sees a partially written configuration.
// Optional feature: define ROUTING_CFG_PARITY_EN to require a trailing XOR
// parity word before the commit is allowed.
module routing_cfg_loader #(
  parameter int NUM_BLOCKS = 2,
  parameter int CFG_W      = 36,
  parameter int WORD_W     = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NUM_BLOCKS*CFG_W-1:0] cfg_out,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int WPB   = CFG_W / WORD_W;
  localparam int TOTAL = NUM_BLOCKS * WPB;
  localparam int SH_W  = NUM_BLOCKS * CFG_W;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SH_W-1:0]   shadow_q;
  logic [SH_W-1:0]   shadow_d;
  logic [SH_W-1:0]   cfg_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
`ifdef ROUTING_CFG_PARITY_EN
  logic [WORD_W-1:0] par_q;
`endif

  // in_ready is the only output decoded directly from the state register
  assign in_ready = (state_q == S_LOAD);
  assign cfg_out  = cfg_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  // Shadow with the slot addressed by the word counter replaced by in_data
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < TOTAL; k++) begin
      shadow_d[k*WORD_W +: WORD_W] = (cnt_q == CNT_W'(k)) ? in_data
                                                          : shadow_q[k*WORD_W +: WORD_W];
    end
  end

  // Session FSM: IDLE -> LOAD (collect words) -> COMMIT (atomic cfg update)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ROUTING_CFG_PARITY_EN
      par_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_LOAD;
            cnt_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
`ifdef ROUTING_CFG_PARITY_EN
            par_q    <= '0;
`endif
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          // abort wins over a transfer presented in the same cycle
          if (abort) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else if (in_valid) begin
            if (cnt_q != TOTAL_C) begin
              shadow_q <= shadow_d;
              cnt_q    <= cnt_q + CNT_W'(1);
`ifdef ROUTING_CFG_PARITY_EN
              par_q    <= par_q ^ in_data;
`else
              if (cnt_q == LAST_C) begin
                state_q <= S_COMMIT;
              end
`endif
            end
`ifdef ROUTING_CFG_PARITY_EN
            // trailing parity word: checked, never stored
            else if (par_q == in_data) begin
              state_q <= S_COMMIT;
            end else begin
              state_q  <= S_IDLE;
              cnt_q    <= '0;
              shadow_q <= '0;
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end
`endif
          end
        end
        S_COMMIT: begin
          cfg_q   <= shadow_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_routing_cfg_loader.sv
// Scoreboard bench for routing_cfg_loader: each session pushes its expected
// (cfg_out, err) result; a monitor pops and compares on every done pulse.
module tb_routing_cfg_loader;

  localparam int WW  = 12;
  localparam int TOT = 6;
  localparam int SHW = 72;
`ifdef ROUTING_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // words packed LSB-first: word k at [k*12 +: 12]
  localparam logic [SHW-1:0] WORDS_A = {12'h000, 12'h000, 12'h040, 12'h000, 12'h000, 12'h080};
  localparam logic [SHW-1:0] WORDS_B = {12'h001, 12'hDEF, 12'h789, 12'h456, 12'h123, 12'hABC};
  // hand-computed results: bit 7 and bit 42 set for A
  localparam logic [SHW-1:0] EXP_A   = 72'h00_0000_0400_0000_0080;
  localparam logic [SHW-1:0] EXP_B   = 72'h00_1DEF_7894_5612_3ABC;
  localparam logic [WW-1:0]  PAR_A   = 12'h0C0;
  localparam logic [WW-1:0]  PAR_B   = 12'h5AE;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic [WW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic [SHW-1:0] cfg_out;
  logic           busy;
  logic           done;
  logic           err;

  routing_cfg_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cfg_out  (cfg_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SHW-1:0] cfg;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [SHW-1:0] act, input logic [SHW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, req);
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check1("unexpected_done", done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("done_cfg", cfg_out, e.cfg);
        check1("done_err", err, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [SHW-1:0] c, input logic e_err);
    exp_t e;
    e.cfg = c;
    e.err = e_err;
    sb_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("busy_after_start", busy, 1'b1);
    check1("ready_after_start", in_ready, 1'b1);
    check1("err_cleared_by_start", err, 1'b0);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input bit gap, input logic [SHW-1:0] prev);
    check1("ready_in_load", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = 12'hFFF;
    if (gap) begin
      check("cfg_stable_during_load", cfg_out, prev);
      tick();
    end
  endtask

  task automatic full_load(input logic [SHW-1:0] words, input logic [WW-1:0] par, input bit bp,
                           input logic [SHW-1:0] prev, input logic [SHW-1:0] exp_cfg,
                           input logic exp_err);
    push_exp(exp_cfg, exp_err);
    do_start();
    for (int i = 0; i < TOT; i++) begin
      send_word(words[i*WW +: WW], bp && (i < TOT-1 || PAR_EN), prev);
    end
    if (PAR_EN) send_word(par, 1'b0, prev);
    if (!exp_err) begin
      // COMMIT cycle: old config still driven
      check1("busy_in_commit", busy, 1'b1);
      check1("ready_in_commit", in_ready, 1'b0);
      check("cfg_before_commit", cfg_out, prev);
      tick();
      check("cfg_one_cycle_after_last", cfg_out, exp_cfg);
    end else begin
      check("cfg_kept_on_error", cfg_out, prev);
    end
    check1("busy_after_session", busy, 1'b0);
    tick();
    check1("ready_idle", in_ready, 1'b0);
    check1("done_single_pulse", done, 1'b0);
  endtask

  initial begin
    // reset while inputs are active
    rst_n    = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b1;
    in_data  = 12'h5A5;
    tick();
    tick();
    check("reset_cfg", cfg_out, 72'h0);
    check1("reset_ready", in_ready, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_err", err, 1'b0);
    start    = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // plain full load
    full_load(WORDS_A, PAR_A, 1'b0, 72'h0, EXP_A, 1'b0);

    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check1("abort_idle_ignored", err, 1'b0);

    // back-pressure: valid toggles 1-0-1
    full_load(WORDS_A, PAR_A, 1'b1, EXP_A, EXP_A, 1'b0);

    // abort after 4 words, same cycle as a valid word
    push_exp(EXP_A, 1'b1);
    do_start();
    for (int i = 0; i < 4; i++) send_word(WORDS_B[i*WW +: WW], 1'b0, EXP_A);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = WORDS_B[4*WW +: WW];
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check1("abort_err", err, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check("abort_cfg_kept", cfg_out, EXP_A);
    tick();
    check1("err_sticky", err, 1'b1);

    // fresh session clears err and loads a dense pattern with back-pressure
    full_load(WORDS_B, PAR_B, 1'b1, EXP_A, EXP_B, 1'b0);

    // reset in the middle of a load
    do_start();
    send_word(WORDS_A[0 +: WW], 1'b0, EXP_B);
    send_word(WORDS_A[WW +: WW], 1'b0, EXP_B);
    rst_n = 1'b0;
    tick();
    tick();
    check("midreset_cfg", cfg_out, 72'h0);
    check1("midreset_ready", in_ready, 1'b0);
    check1("midreset_busy", busy, 1'b0);
    check1("midreset_err", err, 1'b0);
    rst_n = 1'b1;
    tick();
    check1("idle_without_start", in_ready, 1'b0);
    full_load(WORDS_A, PAR_A, 1'b0, 72'h0, EXP_A, 1'b0);

    // wrong parity word rejects the session
    if (PAR_EN) full_load(WORDS_A, 12'h0C1, 1'b0, EXP_A, EXP_A, 1'b1);

    tick();
    check("no_missing_done", 72'(sb_q.size()), 72'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
